// File: rtl/dlfloat_pkg.sv
// dlfloat_pkg
// Shared definitions for the DLFloat16 sequential divider: field widths,
// exponent bias and limits, canonical NaN / infinity encodings, exception
// flag bit positions and the controller state type.
// No ports (package only).

package dlfloat_pkg;

    localparam int DLF_W   = 16;   // full DLFloat16 word
    localparam int EXP_W   = 6;    // exponent field [14:9]
    localparam int MANT_W  = 9;    // stored mantissa field [8:0]
    localparam int SIG_W   = 10;   // mantissa including hidden 1
    localparam int QUO_W   = 12;   // 10 significant + guard + round
    localparam int FLAG_W  = 5;

    localparam int BIAS    = 31;
    localparam int EXP_MAX = 63;

    localparam logic [DLF_W-1:0] QNAN    = 16'h7FFF;
    localparam logic [DLF_W-1:0] INF_POS = 16'h7E00;

    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIVZERO   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM,
        ST_DONE
    } divState_e;

endpackage

// File: rtl/dlfloat_div_lane.sv
// dlfloat_div_lane
// One DLFloat16 division lane: unpacks the operands, classifies special
// cases, runs a restoring mantissa divider BITS_PER_CYCLE bits per step and
// rounds/packs the result. Sequencing comes from the shared controller.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   load_i              capture a_i/b_i (accept cycle)
//   step_i              retire BITS_PER_CYCLE quotient bits
//   norm_i              normalise, round and pack the quotient
//   a_i, b_i            dividend / divisor
//   special_o           combinational: current a_i/b_i form a special case
//   result_o, flags_o   registered quotient and exception flags

module dlfloat_div_lane
    import dlfloat_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              norm_i,
    input  logic [DLF_W-1:0]  a_i,
    input  logic [DLF_W-1:0]  b_i,
    output logic              special_o,
    output logic [DLF_W-1:0]  result_o,
    output logic [FLAG_W-1:0] flags_o
);

    logic [EXP_W-1:0]  expA, expB;
    logic [MANT_W-1:0] mantA, mantB;
    logic              signR;
    logic              zeroA, zeroB, infA, infB, nanA, nanB;
    logic signed [7:0] expRaw;

    assign expA  = a_i[MANT_W +: EXP_W];
    assign expB  = b_i[MANT_W +: EXP_W];
    assign mantA = a_i[MANT_W-1:0];
    assign mantB = b_i[MANT_W-1:0];
    assign signR = a_i[DLF_W-1] ^ b_i[DLF_W-1];

    assign zeroA = (expA == '0);
    assign zeroB = (expB == '0);
    assign infA  = (expA == EXP_W'(EXP_MAX)) && (mantA == '0);
    assign infB  = (expB == EXP_W'(EXP_MAX)) && (mantB == '0);
    assign nanA  = (expA == EXP_W'(EXP_MAX)) && (mantA != '0);
    assign nanB  = (expB == EXP_W'(EXP_MAX)) && (mantB != '0);

    assign special_o = nanA | nanB | infA | infB | zeroA | zeroB;

    // Biased quotient exponent before normalisation; needs sign and headroom
    // because ea-eb+31 spans roughly -30..92.
    assign expRaw = $signed({2'b00, expA}) - $signed({2'b00, expB}) + $signed(8'(BIAS));

    logic [DLF_W-1:0]  specRes;
    logic [FLAG_W-1:0] specFlags;

    // Special-case result, priority ordered: NaN first, then the invalid
    // forms, then the infinity / zero producing forms.
    always_comb begin
        specRes   = '0;
        specFlags = '0;
        if (nanA || nanB) begin
            specRes = QNAN;
        end else if ((zeroA && zeroB) || (infA && infB)) begin
            specRes = QNAN;
            specFlags[FLAG_INVALID] = 1'b1;
        end else if (infA) begin
            specRes = INF_POS | {signR, 15'b0};
        end else if (zeroB) begin
            specRes = INF_POS | {signR, 15'b0};
            specFlags[FLAG_DIVZERO] = 1'b1;
        end else if (zeroA || infB) begin
            specRes = {signR, 15'b0};
        end
    end

    logic              spec_q;
    logic              sign_q;
    logic signed [7:0] exp_q;
    logic [SIG_W:0]    rem_q;
    logic [SIG_W-1:0]  divisor_q;
    logic [QUO_W-1:0]  quo_q;
    logic [DLF_W-1:0]  result_q;
    logic [FLAG_W-1:0] flags_q;

    logic [SIG_W:0]    remStep;
    logic [QUO_W-1:0]  quoStep;

    // Restoring division, unrolled BITS_PER_CYCLE times. The partial
    // remainder always stays below the divisor after a step, so doubling it
    // fits in SIG_W+1 bits; the first quotient bit has weight 2^0.
    always_comb begin
        remStep = rem_q;
        quoStep = quo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (remStep >= {1'b0, divisor_q}) begin
                remStep = remStep - {1'b0, divisor_q};
                quoStep = {quoStep[QUO_W-2:0], 1'b1};
            end else begin
                quoStep = {quoStep[QUO_W-2:0], 1'b0};
            end
            remStep = {remStep[SIG_W-1:0], 1'b0};
        end
    end

    logic              normalized;
    logic [SIG_W-1:0]  sigKeep;
    logic              guardBit, roundBit, stickyBit, roundUp, inexact;
    logic [SIG_W:0]    sigRounded;
    logic signed [7:0] expFinal;
    logic [DLF_W-1:0]  normRes;
    logic [FLAG_W-1:0] normFlags;

    // A quotient below 1 is shifted up one place; the bit that would have
    // been the round bit is then covered by the sticky remainder test.
    assign normalized = quo_q[QUO_W-1];
    assign sigKeep    = normalized ? quo_q[QUO_W-1:2] : quo_q[QUO_W-2:1];
    assign guardBit   = normalized ? quo_q[1] : quo_q[0];
    assign roundBit   = normalized ? quo_q[0] : 1'b0;
    assign stickyBit  = |rem_q;
    assign inexact    = guardBit | roundBit | stickyBit;
    assign roundUp    = guardBit & (roundBit | stickyBit | sigKeep[0]);
    assign sigRounded = {1'b0, sigKeep} + {{SIG_W{1'b0}}, roundUp};
    assign expFinal   = exp_q + (sigRounded[SIG_W] ? 8'sd1 : 8'sd0)
                              - (normalized ? 8'sd0 : 8'sd1);

    // Pack with overflow to infinity and underflow to zero. A mantissa carry
    // leaves the low MANT_W bits all zero, which is the correct 1.0 fraction.
    always_comb begin
        normFlags = '0;
        normFlags[FLAG_INEXACT] = inexact;
        if (expFinal >= $signed(8'(EXP_MAX))) begin
            normRes = INF_POS | {sign_q, 15'b0};
            normFlags[FLAG_OVERFLOW] = 1'b1;
            normFlags[FLAG_INEXACT]  = 1'b1;
        end else if (expFinal <= 8'sd0) begin
            normRes = {sign_q, 15'b0};
            normFlags[FLAG_UNDERFLOW] = 1'b1;
            normFlags[FLAG_INEXACT]   = 1'b1;
        end else begin
            normRes = {sign_q, expFinal[EXP_W-1:0], sigRounded[MANT_W-1:0]};
        end
    end

    // Lane state: load captures operands and the special result up front,
    // steps advance the divider, and the normalise cycle overwrites the
    // result only for lanes that were not special.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_q    <= 1'b0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
        end else if (load_i) begin
            spec_q    <= special_o;
            sign_q    <= signR;
            exp_q     <= expRaw;
            rem_q     <= {2'b01, mantA};
            divisor_q <= {1'b1, mantB};
            quo_q     <= '0;
            result_q  <= specRes;
            flags_q   <= specFlags;
        end else if (step_i) begin
            rem_q     <= remStep;
            quo_q     <= quoStep;
        end else if (norm_i && !spec_q) begin
            result_q  <= normRes;
            flags_q   <= normFlags;
        end
    end

    assign result_o = result_q;
    assign flags_o  = flags_q;

endmodule

// File: rtl/dlfloat_div_seq.sv
// dlfloat_div_seq
// Sequential DLFloat16 divider for LANES independent lanes sharing a single
// IDLE -> DIV -> NORM -> DONE controller with valid/ready handshakes.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   operand bundle handshake (ready only when idle)
//   a, b                packed dividends / divisors, lane i at [16i+15:16i]
//   out_valid/out_ready result bundle handshake
//   c_div               packed quotients
//   exception_flags     per lane {invalid, div_by_zero, overflow, underflow, inexact}

module dlfloat_div_seq
    import dlfloat_pkg::*;
#(
    parameter int LANES          = 1,
    parameter int BITS_PER_CYCLE = 1
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DLF_W*LANES-1:0]  a,
    input  logic [DLF_W*LANES-1:0]  b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DLF_W*LANES-1:0]  c_div,
    output logic [FLAG_W*LANES-1:0] exception_flags
);

    localparam int DIV_CYCLES = (QUO_W + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;

    divState_e                 state_q;
    logic [3:0]                divCount_q;
    logic                      inReady_q;
    logic                      outValid_q;
    logic [DLF_W*LANES-1:0]    cDiv_q;
    logic [FLAG_W*LANES-1:0]   flags_q;

    logic                      laneLoad;
    logic                      allSpecial;
    logic [LANES-1:0]          laneSpecial;
    logic [DLF_W*LANES-1:0]    laneResult;
    logic [FLAG_W*LANES-1:0]   laneFlags;

    assign laneLoad   = (state_q == ST_IDLE) && in_valid && inReady_q;
    assign allSpecial = &laneSpecial;

    for (genvar g = 0; g < LANES; g++) begin : gLane
        dlfloat_div_lane #(
            .BITS_PER_CYCLE(BITS_PER_CYCLE)
        ) uLane (
            .clk       (clk),
            .rst       (rst),
            .load_i    (laneLoad),
            .step_i    (state_q == ST_DIV),
            .norm_i    (state_q == ST_NORM),
            .a_i       (a[DLF_W*g +: DLF_W]),
            .b_i       (b[DLF_W*g +: DLF_W]),
            .special_o (laneSpecial[g]),
            .result_o  (laneResult[DLF_W*g +: DLF_W]),
            .flags_o   (laneFlags[FLAG_W*g +: FLAG_W])
        );
    end

    // Shared controller. DONE spends its first cycle copying lane results
    // into the output registers, so out_valid rises one cycle after DONE is
    // entered and then holds until the consumer takes the bundle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            divCount_q <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            cDiv_q     <= '0;
            flags_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && inReady_q) begin
                        inReady_q  <= 1'b0;
                        divCount_q <= '0;
                        state_q    <= allSpecial ? ST_DONE : ST_DIV;
                    end
                end
                ST_DIV: begin
                    divCount_q <= divCount_q + 4'd1;
                    if (divCount_q == 4'(DIV_CYCLES - 1)) begin
                        state_q <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (!outValid_q) begin
                        outValid_q <= 1'b1;
                        cDiv_q     <= laneResult;
                        flags_q    <= laneFlags;
                    end else if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready        = inReady_q;
    assign out_valid       = outValid_q;
    assign c_div           = cDiv_q;
    assign exception_flags = flags_q;

endmodule

// File: tb/tb_dlfloat_div_seq.sv
// tb_dlfloat_div_seq
// Self-checking bench: a single-lane bit-serial instance and a four-lane,
// two-bits-per-cycle instance, driven with directed and random operands and
// compared against an arithmetic reference of DLFloat16 division.

module tb_dlfloat_div_seq;

    logic        clk;
    logic        rst;

    logic        inValid1, inReady1, outValid1, outReady1;
    logic [15:0] a1, b1, c1;
    logic [4:0]  f1;

    logic        inValid4, inReady4, outValid4, outReady4;
    logic [63:0] a4, b4, c4;
    logic [19:0] f4;

    int checkCount = 0;
    int errorCount = 0;

    dlfloat_div_seq #(.LANES(1), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(inValid1), .in_ready(inReady1),
        .a(a1), .b(b1),
        .out_valid(outValid1), .out_ready(outReady1),
        .c_div(c1), .exception_flags(f1)
    );

    dlfloat_div_seq #(.LANES(4), .BITS_PER_CYCLE(2)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(inValid4), .in_ready(inReady4),
        .a(a4), .b(b4),
        .out_valid(outValid4), .out_ready(outReady4),
        .c_div(c4), .exception_flags(f4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checkCount++;
        if (got !== want) begin
            errorCount++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference division from the number-format rules: exact integer ratio of
    // the significands, then round-to-nearest-even on the discarded part.
    // Returns {special, flags[4:0], result[15:0]}.
    function automatic logic [21:0] refDiv(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, e, sh;
        bit s, zA, zB, iA, iB, nA, nB, up, inex;
        longint num, den, q, r, sig, low, half;
        logic [15:0] infS, zeroS;
        ea = int'(a[14:9]); eb = int'(b[14:9]);
        ma = int'(a[8:0]);  mb = int'(b[8:0]);
        s  = a[15] ^ b[15];
        infS  = {s, 15'h7E00};
        zeroS = {s, 15'h0000};
        zA = (ea == 0); zB = (eb == 0);
        iA = (ea == 63) && (ma == 0); iB = (eb == 63) && (mb == 0);
        nA = (ea == 63) && (ma != 0); nB = (eb == 63) && (mb != 0);
        if (nA || nB)                   return {1'b1, 5'b00000, 16'h7FFF};
        if ((zA && zB) || (iA && iB))   return {1'b1, 5'b10000, 16'h7FFF};
        if (iA)                         return {1'b1, 5'b00000, infS};
        if (zB)                         return {1'b1, 5'b01000, infS};
        if (zA || iB)                   return {1'b1, 5'b00000, zeroS};
        num = longint'(512 + ma) <<< 20;
        den = longint'(512 + mb);
        q = num / den;
        r = num % den;
        e = ea - eb + 31;
        if (q >= (64'sd1 <<< 20)) sh = 11;
        else begin sh = 10; e = e - 1; end
        sig  = q >>> sh;
        low  = q & ((64'sd1 <<< sh) - 1);
        half = 64'sd1 <<< (sh - 1);
        inex = (low != 0) || (r != 0);
        up   = (low > half) || ((low == half) && ((r != 0) || sig[0]));
        if (up) sig = sig + 1;
        if (sig == 1024) begin sig = 512; e = e + 1; end
        if (e >= 63) return {1'b0, 5'b00101, infS};
        if (e <= 0)  return {1'b0, 5'b00011, zeroS};
        return {1'b0, 4'b0000, inex, s, 6'(e), 9'(sig)};
    endfunction

    function automatic logic [15:0] randOperand();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 9))
            0: v[14:9] = 6'd0;
            1: v[14:9] = 6'd63;
            2: begin v[14:9] = 6'd63; v[8:0] = 9'd0; end
            default: ;
        endcase
        return v;
    endfunction

    // Single-lane transaction: check ready, accept, measure latency, check
    // result, optionally stall the consumer, then complete the handshake.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input int stall);
        logic [21:0] exp;
        int lat, expLat;
        exp = refDiv(a, b);
        expLat = exp[21] ? 1 : 14;
        checkOutput("ready1", 64'(inReady1), 64'd1);
        a1 = a; b1 = b; inValid1 = 1'b1;
        @(posedge clk); #1;
        inValid1 = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (outValid1) begin lat = n; break; end
        end
        checkOutput($sformatf("latency1 %h/%h", a, b), 64'(lat), 64'(expLat));
        checkOutput($sformatf("quot1 %h/%h", a, b), 64'(c1), 64'(exp[15:0]));
        checkOutput($sformatf("flags1 %h/%h", a, b), 64'(f1), 64'(exp[20:16]));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            checkOutput("stallValid1", 64'(outValid1), 64'd1);
            checkOutput("stallQuot1", 64'(c1), 64'(exp[15:0]));
        end
        outReady1 = 1'b1;
        @(posedge clk); #1;
        outReady1 = 1'b0;
        checkOutput("drop1", 64'(outValid1), 64'd0);
    endtask

    // Four-lane transaction with the same structure as the single-lane one.
    task automatic applyStimulusQuad(input logic [63:0] a, input logic [63:0] b, input int stall);
        logic [21:0] r;
        logic [63:0] expC;
        logic [19:0] expF;
        bit allSpec;
        int lat, expLat;
        allSpec = 1'b1;
        for (int l = 0; l < 4; l++) begin
            r = refDiv(a[16*l +: 16], b[16*l +: 16]);
            expC[16*l +: 16] = r[15:0];
            expF[5*l +: 5]   = r[20:16];
            allSpec = allSpec & r[21];
        end
        expLat = allSpec ? 1 : 8;
        checkOutput("ready4", 64'(inReady4), 64'd1);
        a4 = a; b4 = b; inValid4 = 1'b1;
        @(posedge clk); #1;
        inValid4 = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (outValid4) begin lat = n; break; end
        end
        checkOutput($sformatf("latency4 %h/%h", a, b), 64'(lat), 64'(expLat));
        checkOutput($sformatf("quot4 %h/%h", a, b), c4, expC);
        checkOutput($sformatf("flags4 %h/%h", a, b), 64'(f4), 64'(expF));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            checkOutput("stallValid4", 64'(outValid4), 64'd1);
            checkOutput("stallQuot4", c4, expC);
            checkOutput("stallFlags4", 64'(f4), 64'(expF));
            checkOutput("stallReady4", 64'(inReady4), 64'd0);
        end
        outReady4 = 1'b1;
        @(posedge clk); #1;
        outReady4 = 1'b0;
        checkOutput("drop4", 64'(outValid4), 64'd0);
    endtask

    initial begin
        bit sawValid;
        logic [63:0] qa, qb;

        rst = 1'b1;
        inValid1 = 1'b0; outReady1 = 1'b0; a1 = '0; b1 = '0;
        inValid4 = 1'b0; outReady4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstReady1", 64'(inReady1), 64'd1);
        checkOutput("rstValid1", 64'(outValid1), 64'd0);
        checkOutput("rstQuot1",  64'(c1), 64'd0);
        checkOutput("rstFlags1", 64'(f1), 64'd0);
        checkOutput("rstValid4", 64'(outValid4), 64'd0);
        checkOutput("rstQuot4",  c4, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed single-lane vectors");
        applyStimulus(16'h4000, 16'h3E00, 3);
        applyStimulus(16'h3F00, 16'h4000, 0);
        applyStimulus(16'h3E00, 16'h4100, 0);
        applyStimulus(16'h3E00, 16'h8000, 0);
        applyStimulus(16'h0000, 16'h0000, 0);
        applyStimulus(16'h7E00, 16'hFE00, 0);
        applyStimulus(16'h7DFF, 16'h0200, 0);
        applyStimulus(16'h0200, 16'h7DFF, 0);
        applyStimulus(16'h7E05, 16'h3E00, 0);
        applyStimulus(16'hFE00, 16'h0000, 0);
        applyStimulus(16'h3FFF, 16'hBE01, 0);

        $display("[TB] random single-lane vectors");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(randOperand(), randOperand(), 0);
        end

        $display("[TB] mixed four-lane bundle");
        applyStimulusQuad({16'h3E00, 16'h7DFF, 16'h3E00, 16'h4000},
                          {16'h4100, 16'h0200, 16'h8000, 16'h3E00}, 5);
        applyStimulusQuad({16'h0000, 16'h7E00, 16'h7FFF, 16'h3E00},
                          {16'h4000, 16'h4000, 16'h3E00, 16'h0000}, 0);

        $display("[TB] random four-lane bundles");
        for (int i = 0; i < 25; i++) begin
            for (int l = 0; l < 4; l++) begin
                qa[16*l +: 16] = randOperand();
                qb[16*l +: 16] = randOperand();
            end
            applyStimulusQuad(qa, qb, 0);
        end

        $display("[TB] reset during division");
        a1 = 16'h4000; b1 = 16'h3E00; inValid1 = 1'b1;
        @(posedge clk); #1;
        inValid1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        inValid1 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        inValid1 = 1'b0;
        checkOutput("postRstReady", 64'(inReady1), 64'd1);
        checkOutput("postRstValid", 64'(outValid1), 64'd0);
        checkOutput("postRstQuot",  64'(c1), 64'd0);
        sawValid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (outValid1) sawValid = 1'b1;
        end
        checkOutput("noValidAfterRst", 64'(sawValid), 64'd0);
        applyStimulus(16'h4000, 16'h3E00, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
